// File: rtl/cmac_tx_axis_arbiter.sv
// Packet-level round-robin arbiter: two 512-bit AXI4-Stream sources onto the CMAC TX port.
// Whole packets only, with runaway-packet truncation and per-source statistics.
module cmac_tx_axis_arbiter #(
    parameter int MAX_BEATS = 256,
    parameter int CNT_W     = 32
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             tx_enable,

    input  logic [511:0]     s0_axis_tdata,
    input  logic [63:0]      s0_axis_tkeep,
    input  logic             s0_axis_tvalid,
    input  logic             s0_axis_tlast,
    input  logic             s0_axis_tuser,
    output logic             s0_axis_tready,

    input  logic [511:0]     s1_axis_tdata,
    input  logic [63:0]      s1_axis_tkeep,
    input  logic             s1_axis_tvalid,
    input  logic             s1_axis_tlast,
    input  logic             s1_axis_tuser,
    output logic             s1_axis_tready,

    output logic [511:0]     m_axis_tdata,
    output logic [63:0]      m_axis_tkeep,
    output logic             m_axis_tvalid,
    output logic             m_axis_tlast,
    output logic             m_axis_tuser,
    input  logic             m_axis_tready,

    output logic [1:0]       grant,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1,
    output logic [15:0]      trunc_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GNT0,
        S_GNT1,
        S_DRAIN0,
        S_DRAIN1
    } state_t;

    localparam logic [15:0] LAST_BEAT = 16'(MAX_BEATS - 1);

    state_t           r_state;
    state_t           w_next;
    logic             r_last_owner;
    logic [15:0]      r_beat_cnt;
    logic [CNT_W-1:0] r_pkt_cnt0;
    logic [CNT_W-1:0] r_pkt_cnt1;
    logic [15:0]      r_trunc_cnt;

    logic             w_own1;
    logic             w_gnt;
    logic             w_drain;
    logic [511:0]     w_sd;
    logic [63:0]      w_sk;
    logic             w_sv;
    logic             w_sl;
    logic             w_su;
    logic             w_at_limit;
    logic             w_hs;

    // Mux of the owning source; only meaningful while granted or draining.
    always_comb begin
        w_own1     = (r_state == S_GNT1) || (r_state == S_DRAIN1);
        w_gnt      = (r_state == S_GNT0) || (r_state == S_GNT1);
        w_drain    = (r_state == S_DRAIN0) || (r_state == S_DRAIN1);
        w_sd       = w_own1 ? s1_axis_tdata  : s0_axis_tdata;
        w_sk       = w_own1 ? s1_axis_tkeep  : s0_axis_tkeep;
        w_sv       = w_own1 ? s1_axis_tvalid : s0_axis_tvalid;
        w_sl       = w_own1 ? s1_axis_tlast  : s0_axis_tlast;
        w_su       = w_own1 ? s1_axis_tuser  : s0_axis_tuser;
        w_at_limit = w_gnt && !w_sl && (r_beat_cnt == LAST_BEAT);
        w_hs       = w_gnt && w_sv && m_axis_tready;
    end

    always_comb begin
        m_axis_tdata   = '0;
        m_axis_tkeep   = '0;
        m_axis_tvalid  = 1'b0;
        m_axis_tlast   = 1'b0;
        m_axis_tuser   = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        w_next         = r_state;

        if (w_gnt) begin
            m_axis_tdata  = w_sd;
            m_axis_tkeep  = w_sk;
            m_axis_tvalid = w_sv;
            // Forced end-of-packet, flagged as errored so the MAC aborts the frame.
            m_axis_tlast  = w_sl || w_at_limit;
            m_axis_tuser  = w_su || w_at_limit;
        end

        s0_axis_tready = ((r_state == S_GNT0) && m_axis_tready) || (r_state == S_DRAIN0);
        s1_axis_tready = ((r_state == S_GNT1) && m_axis_tready) || (r_state == S_DRAIN1);

        case (r_state)
            S_IDLE: begin
                if (tx_enable) begin
                    if (s0_axis_tvalid && s1_axis_tvalid)
                        w_next = r_last_owner ? S_GNT0 : S_GNT1;
                    else if (s0_axis_tvalid)
                        w_next = S_GNT0;
                    else if (s1_axis_tvalid)
                        w_next = S_GNT1;
                end
            end
            S_GNT0, S_GNT1: begin
                if (w_hs && w_sl)
                    w_next = S_IDLE;
                else if (w_hs && w_at_limit)
                    w_next = w_own1 ? S_DRAIN1 : S_DRAIN0;
            end
            S_DRAIN0, S_DRAIN1: begin
                if (w_sv && w_sl)
                    w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_last_owner <= 1'b1;
            r_beat_cnt   <= '0;
            r_pkt_cnt0   <= '0;
            r_pkt_cnt1   <= '0;
            r_trunc_cnt  <= '0;
        end else begin
            r_state <= w_next;
            if (w_hs) begin
                if (w_sl) begin
                    r_beat_cnt   <= '0;
                    r_last_owner <= w_own1;
                    if (w_own1) r_pkt_cnt1 <= r_pkt_cnt1 + 1'b1;
                    else        r_pkt_cnt0 <= r_pkt_cnt0 + 1'b1;
                end else if (w_at_limit) begin
                    r_beat_cnt   <= '0;
                    r_last_owner <= w_own1;
                    if (r_trunc_cnt != 16'hFFFF) r_trunc_cnt <= r_trunc_cnt + 1'b1;
                end else begin
                    r_beat_cnt <= r_beat_cnt + 1'b1;
                end
            end
        end
    end

    assign grant     = {(r_state == S_GNT1) || (r_state == S_DRAIN1),
                        (r_state == S_GNT0) || (r_state == S_DRAIN0)};
    assign pkt_cnt0  = r_pkt_cnt0;
    assign pkt_cnt1  = r_pkt_cnt1;
    assign trunc_cnt = r_trunc_cnt;

endmodule

// File: tb/tb_cmac_tx_axis_arbiter.sv
// Scoreboard bench for cmac_tx_axis_arbiter with MAX_BEATS=4: per-source beat drivers,
// an expected-beat queue filled by the stimulus, and a monitor that checks every m_axis handshake.
module tb_cmac_tx_axis_arbiter;

    localparam int MAXB  = 4;
    localparam int CNT_W = 32;

    typedef struct packed {
        logic [511:0] d;
        logic [63:0]  k;
        logic         l;
        logic         u;
    } beat_t;

    logic             aclk, aresetn, tx_enable;
    logic [511:0]     s0_axis_tdata, s1_axis_tdata, m_axis_tdata;
    logic [63:0]      s0_axis_tkeep, s1_axis_tkeep, m_axis_tkeep;
    logic             s0_axis_tvalid, s0_axis_tlast, s0_axis_tuser, s0_axis_tready;
    logic             s1_axis_tvalid, s1_axis_tlast, s1_axis_tuser, s1_axis_tready;
    logic             m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tready;
    logic [1:0]       grant;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;
    logic [15:0]      trunc_cnt;

    beat_t q0[$];
    beat_t q1[$];
    beat_t expq[$];
    int    n_vec = 0;
    int    n_err = 0;

    cmac_tx_axis_arbiter #(.MAX_BEATS(MAXB), .CNT_W(CNT_W)) dut (
        .aclk(aclk), .aresetn(aresetn), .tx_enable(tx_enable),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tkeep(s0_axis_tkeep),
        .s0_axis_tvalid(s0_axis_tvalid), .s0_axis_tlast(s0_axis_tlast),
        .s0_axis_tuser(s0_axis_tuser), .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tkeep(s1_axis_tkeep),
        .s1_axis_tvalid(s1_axis_tvalid), .s1_axis_tlast(s1_axis_tlast),
        .s1_axis_tuser(s1_axis_tuser), .s1_axis_tready(s1_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast),
        .m_axis_tuser(m_axis_tuser), .m_axis_tready(m_axis_tready),
        .grant(grant), .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1), .trunc_cnt(trunc_cnt)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    function automatic logic [511:0] mk_data(input int src, input int pkt, input int b);
        logic [31:0] w;
        w = {src[7:0], pkt[7:0], b[15:0]};
        return {16{w}};
    endfunction

    function automatic beat_t mk_beat(input int src, input int pkt, input int b, input int n);
        beat_t x;
        x.d = mk_data(src, pkt, b);
        x.k = (b == n - 1) ? 64'h0000_0000_FFFF_FFFF : '1;
        x.l = (b == n - 1);
        x.u = (b == n - 1) && (pkt % 2 == 1);
        return x;
    endfunction

    task automatic src_push(input int src, input int pkt, input int n);
        for (int b = 0; b < n; b++) begin
            if (src == 0) q0.push_back(mk_beat(src, pkt, b, n));
            else          q1.push_back(mk_beat(src, pkt, b, n));
        end
    endtask

    // Expected m_axis beats: packets longer than MAXB are cut at beat MAXB with tlast/tuser forced.
    task automatic exp_push(input int src, input int pkt, input int n);
        int nout;
        beat_t x;
        nout = (n > MAXB) ? MAXB : n;
        for (int b = 0; b < nout; b++) begin
            x = mk_beat(src, pkt, b, n);
            if (n > MAXB && b == nout - 1) begin
                x.l = 1'b1;
                x.u = 1'b1;
            end
            expq.push_back(x);
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int t;
        t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while ((q0.size() != 0 || q1.size() != 0 || expq.size() != 0 || grant != 2'b00) && t < 200);
        if (t >= 200) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: timeout, q0=%0d q1=%0d exp=%0d grant=%b",
                     nm, q0.size(), q1.size(), expq.size(), grant);
        end
    endtask

    // Source drivers: handshake sampled at negedge, next beat presented just after posedge.
    initial begin
        logic h;
        s0_axis_tvalid = 1'b0; s0_axis_tdata = '0; s0_axis_tkeep = '0;
        s0_axis_tlast = 1'b0;  s0_axis_tuser = 1'b0;
        forever begin
            @(negedge aclk);
            h = s0_axis_tvalid && s0_axis_tready && aresetn;
            @(posedge aclk);
            #1;
            if (h && q0.size() > 0) void'(q0.pop_front());
            if (q0.size() > 0) begin
                s0_axis_tvalid = 1'b1;
                {s0_axis_tdata, s0_axis_tkeep, s0_axis_tlast, s0_axis_tuser} = q0[0];
            end else begin
                s0_axis_tvalid = 1'b0;
            end
        end
    end

    initial begin
        logic h;
        s1_axis_tvalid = 1'b0; s1_axis_tdata = '0; s1_axis_tkeep = '0;
        s1_axis_tlast = 1'b0;  s1_axis_tuser = 1'b0;
        forever begin
            @(negedge aclk);
            h = s1_axis_tvalid && s1_axis_tready && aresetn;
            @(posedge aclk);
            #1;
            if (h && q1.size() > 0) void'(q1.pop_front());
            if (q1.size() > 0) begin
                s1_axis_tvalid = 1'b1;
                {s1_axis_tdata, s1_axis_tkeep, s1_axis_tlast, s1_axis_tuser} = q1[0];
            end else begin
                s1_axis_tvalid = 1'b0;
            end
        end
    end

    // Monitor: every accepted m_axis beat must match the head of the expected queue.
    initial begin
        beat_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && m_axis_tvalid && m_axis_tready) begin
                n_vec++;
                if (expq.size() == 0) begin
                    n_err++;
                    $display("FAIL m_beat: unexpected beat data[31:0]=%h last=%b", m_axis_tdata[31:0], m_axis_tlast);
                end else begin
                    e = expq.pop_front();
                    if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser} !== e) begin
                        n_err++;
                        $display("FAIL m_beat: got data[31:0]=%h keep=%h last=%b user=%b expected data[31:0]=%h keep=%h last=%b user=%b",
                                 m_axis_tdata[31:0], m_axis_tkeep, m_axis_tlast, m_axis_tuser,
                                 e.d[31:0], e.k, e.l, e.u);
                    end
                end
            end
        end
    end

    initial begin
        int t;
        aresetn = 1'b0;
        tx_enable = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("rst_grant", 64'(grant), 64'h0);
        chk("rst_mvalid", 64'(m_axis_tvalid), 64'h0);
        chk("rst_s0rdy", 64'(s0_axis_tready), 64'h0);
        chk("rst_s1rdy", 64'(s1_axis_tready), 64'h0);
        chk("rst_pkt0", 64'(pkt_cnt0), 64'h0);
        chk("rst_pkt1", 64'(pkt_cnt1), 64'h0);
        chk("rst_trunc", 64'(trunc_cnt), 64'h0);
        @(posedge aclk);
        #3 aresetn = 1'b1;
        @(negedge aclk);

        // Both sources saturated with 2-beat packets: strict alternation starting at s0.
        src_push(0, 1, 2); src_push(1, 2, 2); src_push(0, 3, 2); src_push(1, 4, 2);
        exp_push(0, 1, 2); exp_push(1, 2, 2); exp_push(0, 3, 2); exp_push(1, 4, 2);
        wait_idle("rr_done");
        chk("rr_pkt0", 64'(pkt_cnt0), 64'd2);
        chk("rr_pkt1", 64'(pkt_cnt1), 64'd2);

        // Lone s0 3-beat packet: one bubble in IDLE, then granted.
        src_push(0, 5, 3);
        exp_push(0, 5, 3);
        @(negedge aclk);
        chk("s0_bubble_grant", 64'(grant), 64'h0);
        chk("s0_bubble_rdy", 64'(s0_axis_tready), 64'h0);
        @(negedge aclk);
        chk("s0_grant", 64'(grant), 64'h1);
        chk("s0_mvalid", 64'(m_axis_tvalid), 64'h1);
        wait_idle("s0_done");
        chk("s0_pkt0", 64'(pkt_cnt0), 64'd3);
        chk("s0_grant_after", 64'(grant), 64'h0);

        // s1 6-beat packet truncated at 4; last two beats drained silently.
        src_push(1, 10, 6);
        exp_push(1, 10, 6);
        wait_idle("trunc_done");
        chk("trunc_cnt", 64'(trunc_cnt), 64'd1);
        chk("trunc_pkt1", 64'(pkt_cnt1), 64'd2);

        // Link down holds off the start; dropping it mid-packet does not cut the packet.
        tx_enable = 1'b0;
        src_push(0, 12, 4);
        exp_push(0, 12, 4);
        repeat (5) @(negedge aclk);
        chk("txen_grant", 64'(grant), 64'h0);
        chk("txen_s0rdy", 64'(s0_axis_tready), 64'h0);
        chk("txen_mvalid", 64'(m_axis_tvalid), 64'h0);
        tx_enable = 1'b1;
        t = 0;
        while (expq.size() > 2 && t < 100) begin
            @(posedge aclk);
            t++;
        end
        chk("txen_wait_timeout", 64'(t >= 100), 64'h0);
        #2 tx_enable = 1'b0;
        wait_idle("txen_done");
        chk("txen_pkt0", 64'(pkt_cnt0), 64'd4);
        tx_enable = 1'b1;

        // Backpressure 1,0,0,1 across a 2-beat s1 packet.
        src_push(1, 20, 2);
        exp_push(1, 20, 2);
        t = 0;
        do begin
            @(negedge aclk);
            t++;
        end while (grant != 2'b10 && t < 50);
        chk("bp_grant", 64'(grant), 64'h2);
        @(posedge aclk);
        #2 m_axis_tready = 1'b0;
        @(negedge aclk);
        chk("bp_hold1_valid", 64'(m_axis_tvalid), 64'h1);
        chk("bp_hold1_data", m_axis_tdata[63:0], mk_data(1, 20, 1) & 512'(64'hFFFF_FFFF_FFFF_FFFF));
        @(posedge aclk);
        @(negedge aclk);
        chk("bp_hold2_data", m_axis_tdata[63:0], mk_data(1, 20, 1) & 512'(64'hFFFF_FFFF_FFFF_FFFF));
        chk("bp_hold2_last", 64'(m_axis_tlast), 64'h1);
        chk("bp_hold_pkt1", 64'(pkt_cnt1), 64'd2);
        @(posedge aclk);
        #2 m_axis_tready = 1'b1;
        wait_idle("bp_done");
        chk("bp_pkt1", 64'(pkt_cnt1), 64'd3);

        // Reset in the middle of an s1 packet, then a both-request race that s0 must win.
        src_push(1, 22, 4);
        exp_push(1, 22, 4);
        t = 0;
        while (expq.size() > 3 && t < 50) begin
            @(posedge aclk);
            t++;
        end
        chk("rst_mid_wait_timeout", 64'(t >= 50), 64'h0);
        #2 aresetn = 1'b0;
        q1.delete();
        expq.delete();
        @(posedge aclk);
        #3 aresetn = 1'b1;
        @(negedge aclk);
        chk("rmid_grant", 64'(grant), 64'h0);
        chk("rmid_mvalid", 64'(m_axis_tvalid), 64'h0);
        chk("rmid_pkt0", 64'(pkt_cnt0), 64'h0);
        chk("rmid_pkt1", 64'(pkt_cnt1), 64'h0);
        chk("rmid_trunc", 64'(trunc_cnt), 64'h0);
        src_push(0, 30, 1);
        src_push(1, 31, 1);
        exp_push(0, 30, 1);
        exp_push(1, 31, 1);
        wait_idle("post_rst_done");
        chk("post_rst_pkt0", 64'(pkt_cnt0), 64'd1);
        chk("post_rst_pkt1", 64'(pkt_cnt1), 64'd1);

        repeat (3) @(negedge aclk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cmac_tx_axis_arbiter.md
Name: cmac_tx_axis_arbiter

Overview:
- Packet-level round-robin arbiter that shares the single CMAC TX AXI4-Stream port between two 512-bit sources: source 0 is the ERNIC transmit stream, source 1 is the local packet generator.
- Sits between both sources and the cmac_usplus_0 tx_axis interface, clocked by txusrclk2.
- Never interleaves beats of different packets.
- Truncates runaway packets and keeps per-source statistics.

Parameters:
- MAX_BEATS, 256: maximum beats per packet before forced truncation (1..65535).
- CNT_W, 32: width of the per-source packet counters.

Ports:
- aclk  in  1  CMAC TX user clock (txusrclk2).
- aresetn  in  1  synchronous active-low reset.
- tx_enable  in  1  link ready (ctl_tx_enable AND rx aligned); gates the start of new packets only.
- s0_axis_tdata  in  512  source 0 data.
- s0_axis_tkeep  in  64  source 0 byte enables.
- s0_axis_tvalid  in  1  source 0 valid.
- s0_axis_tlast  in  1  source 0 end of packet.
- s0_axis_tuser  in  1  source 0 error flag.
- s0_axis_tready  out  1  source 0 ready.
- s1_axis_tdata/tkeep/tvalid/tlast/tuser/tready: same widths and directions as s0, for source 1.
- m_axis_tdata  out  512  to CMAC tx_axis_tdata.
- m_axis_tkeep  out  64  to CMAC tx_axis_tkeep.
- m_axis_tvalid  out  1  to CMAC tx_axis_tvalid.
- m_axis_tlast  out  1  to CMAC tx_axis_tlast.
- m_axis_tuser  out  1  to CMAC tx_axis_tuser.
- m_axis_tready  in  1  from CMAC tx_axis_tready.
- grant  out  2  one-hot current owner (01 = src0, 10 = src1, 00 = none).
- pkt_cnt0  out  CNT_W  packets completed from source 0.
- pkt_cnt1  out  CNT_W  packets completed from source 1.
- trunc_cnt  out  16  packets truncated (saturating).

Behaviour:
- Reset (aresetn=0 at a rising aclk edge):
  - state=IDLE, grant=00, last_owner=1 (so source 0 wins first), beat_cnt=0.
  - All counters 0; m_axis_tvalid=0; s*_axis_tready=0.
- States:
  - IDLE: no traffic passes; all readies 0, m_axis_tvalid=0.
  - If tx_enable=1 and any s*_tvalid=1, choose next state from the requesting sources. If both request, pick the source not equal to last_owner.
  - Go to GNT0 or GNT1 on the next edge. One bubble cycle per packet is accepted.
  - If tx_enable=0, stay in IDLE regardless of requests.
- GNTx (combinational pass-through, zero latency):
  - m_axis_* = sx_axis_*; sx_tready = m_axis_tready; the other source's tready=0.
  - On each handshake (sx_tvalid & m_axis_tready), beat_cnt increments.
  - On a handshake with tlast=1: pkt_cntx increments (wraps at 2^CNT_W), last_owner=x, beat_cnt=0, go to IDLE.
  - On a handshake with tlast=0 when beat_cnt==MAX_BEATS-1: drive m_axis_tlast=1 and m_axis_tuser=1 on that beat, increment trunc_cnt (saturates at 0xFFFF), set last_owner=x, go to DRAINx. pkt_cntx does not increment.
  - tx_enable falling mid-packet is ignored; the packet always completes.
- DRAINx:
  - sx_tready=1, m_axis_tvalid=0; source beats are discarded.
  - On a source beat with tlast=1: beat_cnt=0, go to IDLE.
- grant reflects state: 01 in GNT0/DRAIN0, 10 in GNT1/DRAIN1, 00 in IDLE.
- A single-beat packet (tvalid & tlast on the first beat) completes in GNTx in one cycle.
- A source deasserting tvalid mid-packet keeps ownership; the arbiter never preempts.
- m_axis_tready=0 holds all state; beat_cnt only counts handshakes.
- Reset mid-packet drops the packet immediately; outputs return to reset values on the next edge.

Test Plan:
- Only s0 sends a 3-beat packet, tready=1, tx_enable=1 -> grant=01 from cycle 2, three beats appear unchanged on m_axis with tlast on beat 3; pkt_cnt0=1, grant=00 afterwards.
- Both sources continuously present 2-beat packets -> order on m_axis is s0,s1,s0,s1; after 4 packets pkt_cnt0=2 and pkt_cnt1=2; no beat of one packet interleaves with the other.
- MAX_BEATS=4, s1 sends a 6-beat packet -> m_axis carries 4 beats, the 4th with tlast=1 and tuser=1; beats 5-6 are accepted with m_axis_tvalid=0; trunc_cnt=1, pkt_cnt1=0.
- tx_enable=0 with s0_tvalid=1 -> stays in IDLE, s0_tready=0. Raising tx_enable starts the packet. Dropping tx_enable on beat 2 of 4 -> all 4 beats still sent.
- m_axis_tready toggled 1,0,0,1 during a 2-beat packet -> data held stable while tready=0; exactly 2 handshakes; beat_cnt=0 afterwards.
- aresetn pulsed low mid-packet in GNT1 -> next edge: grant=00, m_axis_tvalid=0, all counters 0; the next arbitration favours s0.
